// File: rtl/ysyx_22050612_pkg.sv
// Shared constants for the writeback slice: load size encodings and default widths.
package ysyx_22050612_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] LS_SIZE_B = 2'd0;
  localparam logic [1:0] LS_SIZE_H = 2'd1;
  localparam logic [1:0] LS_SIZE_W = 2'd2;
  localparam logic [1:0] LS_SIZE_D = 2'd3;

endpackage

// File: rtl/ysyx_22050612_load_align.sv
// Combinational load formatter: shifts the addressed lane down, masks to the access size and
// sign- or zero-extends to the full register width.
module ysyx_22050612_load_align
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] ls_data,
  input  logic [1:0]            ls_size,
  input  logic                  ls_unsigned,
  input  logic [OFF_WIDTH-1:0]  ls_offset,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  sext;

  // Misaligned lanes fall off the top and read back as zero before extension.
  assign shifted = ls_data >> {ls_offset, 3'b000};
  assign sext    = !ls_unsigned;

  always_comb begin
    load_data = shifted;
    unique case (ls_size)
      LS_SIZE_B: load_data = {{(DATA_WIDTH - 8){sext & shifted[7]}}, shifted[7:0]};
      LS_SIZE_H: load_data = {{(DATA_WIDTH - 16){sext & shifted[15]}}, shifted[15:0]};
      LS_SIZE_W: load_data = {{(DATA_WIDTH - 32){sext & shifted[31]}}, shifted[31:0]};
      LS_SIZE_D: load_data = shifted;
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22050612_writeback_unit.sv
// Writeback stage: arbitrates EXU/LSU results (LSU first), registers the RF write port,
// tracks pending destinations for decode hazard stalls and counts retirements.
module ysyx_22050612_writeback_unit
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                iss_valid,
  input  logic                                iss_wen,
  input  logic [ADDR_WIDTH-1:0]               iss_rd,
  output logic                                iss_ready,
  input  logic [ADDR_WIDTH-1:0]               rs1,
  input  logic [ADDR_WIDTH-1:0]               rs2,
  output logic                                rs1_busy,
  output logic                                rs2_busy,
  input  logic                                ex_valid,
  output logic                                ex_ready,
  input  logic                                ex_wen,
  input  logic [ADDR_WIDTH-1:0]               ex_rd,
  input  logic [DATA_WIDTH-1:0]               ex_data,
  input  logic                                ls_valid,
  output logic                                ls_ready,
  input  logic [ADDR_WIDTH-1:0]               ls_rd,
  input  logic [DATA_WIDTH-1:0]               ls_data,
  input  logic [1:0]                          ls_size,
  input  logic                                ls_unsigned,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     ls_offset,
  output logic                                rf_wen,
  output logic [ADDR_WIDTH-1:0]               rf_waddr,
  output logic [DATA_WIDTH-1:0]               rf_wdata,
  output logic                                wb_valid,
  output logic [63:0]                         retire_cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] load_data;
  logic                  accept;
  logic                  sel_writes;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  issue_set;

  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  wb_valid_q;
  logic [63:0]           retire_q;
  logic [NumRegs-1:0]    pending_q, pending_d;

  ysyx_22050612_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .ls_data     (ls_data),
    .ls_size     (ls_size),
    .ls_unsigned (ls_unsigned),
    .ls_offset   (ls_offset),
    .load_data   (load_data)
  );

  assign ls_ready = 1'b1;
  assign ex_ready = !ls_valid;
  assign accept   = ls_valid || ex_valid;

  always_comb begin
    if (ls_valid) begin
      sel_writes = 1'b1;
      sel_rd     = ls_rd;
      sel_data   = load_data;
    end else begin
      sel_writes = ex_wen;
      sel_rd     = ex_rd;
      sel_data   = ex_data;
    end
  end

  assign iss_ready = !(iss_wen && pending_q[iss_rd]);
  assign issue_set = iss_valid && iss_ready && iss_wen && (iss_rd != '0);

  // Clear lands on the RF commit edge, so a busy source reads fresh data the cycle after.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q) pending_d[rf_waddr_q] = 1'b0;
    if (issue_set) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      retire_q   <= '0;
      pending_q  <= '0;
    end else begin
      rf_wen_q   <= accept && sel_writes && (sel_rd != '0);
      wb_valid_q <= accept;
      pending_q  <= pending_d;
      if (accept) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
        retire_q   <= retire_q + 64'd1;
      end
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign retire_cnt = retire_q;
  assign rs1_busy   = pending_q[rs1];
  assign rs2_busy   = pending_q[rs2];

endmodule

// File: tb/tb_ysyx_22050612_writeback_unit.sv
// Directed self-checking bench for the writeback unit.
module tb_ysyx_22050612_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_wen, iss_ready;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        ex_valid, ex_ready, ex_wen;
  logic [4:0]  ex_rd;
  logic [63:0] ex_data;
  logic        ls_valid, ls_ready;
  logic [4:0]  ls_rd;
  logic [63:0] ls_data;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [2:0]  ls_offset;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_valid;
  logic [63:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_retire = 64'd0;

  always #5 clk = ~clk;

  ysyx_22050612_writeback_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_wen     (iss_wen),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_wen      (ex_wen),
    .ex_rd       (ex_rd),
    .ex_data     (ex_data),
    .ls_valid    (ls_valid),
    .ls_ready    (ls_ready),
    .ls_rd       (ls_rd),
    .ls_data     (ls_data),
    .ls_size     (ls_size),
    .ls_unsigned (ls_unsigned),
    .ls_offset   (ls_offset),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_valid    (wb_valid),
    .retire_cnt  (retire_cnt)
  );

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    ex_valid = 0; ex_wen = 0; ex_rd = 0; ex_data = 0;
    ls_valid = 0; ls_rd = 0; ls_data = 0; ls_size = 0; ls_unsigned = 0; ls_offset = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    n_cmp++; if (retire_cnt !== 64'd0) begin n_bad++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
    @(negedge clk); rst_n = 1;
    // In-flight EXU write and an issue, then reset lands before they drain.
    @(negedge clk);
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd3; ex_data = 64'hBEEF;
    iss_valid = 1; iss_wen = 1; iss_rd = 5'd9; rs1 = 5'd9;
    @(posedge clk); #2;
    rst_n = 0;
    @(negedge clk);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL midreset_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_wb_valid got %b want 0", wb_valid); end
    n_cmp++; if (retire_cnt !== 64'd0) begin n_bad++; $display("FAIL midreset_retire got %0d want 0", retire_cnt); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", rs1_busy); end
    idle(); rs1 = 5'd9;
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL postreset_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL postreset_busy got %b want 0", rs1_busy); end
    exp_retire = 0;
  endtask

  task automatic test_ex_write();
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd5; ex_data = 64'h1234;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL ex_ready got %b want 1", ex_ready); end
    @(negedge clk);
    idle();
    exp_retire++;
    n_cmp++; if (rf_wen !== 1'b1) begin n_bad++; $display("FAIL ex_rf_wen got %b want 1", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_bad++; $display("FAIL ex_waddr got %0d want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'h1234) begin n_bad++; $display("FAIL ex_wdata got %h want 1234", rf_wdata); end
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL ex_wb_valid got %b want 1", wb_valid); end
    n_cmp++; if (retire_cnt !== exp_retire) begin n_bad++; $display("FAIL ex_retire got %0d want %0d", retire_cnt, exp_retire); end
    @(negedge clk);
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL ex_idle_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL ex_idle_wb_valid got %b want 0", wb_valid); end
  endtask

  task automatic test_load_extend();
    logic [63:0] v_data [6];
    logic [1:0]  v_size [6];
    logic        v_uns  [6];
    logic [2:0]  v_off  [6];
    logic [63:0] v_exp  [6];
    v_data[0] = 64'h00000000_80FF0000; v_size[0] = 2'd1; v_uns[0] = 0; v_off[0] = 3'd2; v_exp[0] = 64'hFFFFFFFF_FFFF80FF;
    v_data[1] = 64'h00000000_80FF0000; v_size[1] = 2'd1; v_uns[1] = 1; v_off[1] = 3'd2; v_exp[1] = 64'h00000000_000080FF;
    v_data[2] = 64'h81000000_00000000; v_size[2] = 2'd0; v_uns[2] = 0; v_off[2] = 3'd7; v_exp[2] = 64'hFFFFFFFF_FFFFFF81;
    v_data[3] = 64'h7FFFFFFF_00000000; v_size[3] = 2'd2; v_uns[3] = 0; v_off[3] = 3'd4; v_exp[3] = 64'h00000000_7FFFFFFF;
    v_data[4] = 64'hDEADBEEF_CAFEF00D; v_size[4] = 2'd3; v_uns[4] = 0; v_off[4] = 3'd0; v_exp[4] = 64'hDEADBEEF_CAFEF00D;
    v_data[5] = 64'hABCD0000_00000000; v_size[5] = 2'd2; v_uns[5] = 0; v_off[5] = 3'd6; v_exp[5] = 64'h00000000_0000ABCD;
    for (int i = 0; i < 6; i++) begin
      ls_valid = 1; ls_rd = 5'(10 + i); ls_data = v_data[i]; ls_size = v_size[i];
      ls_unsigned = v_uns[i]; ls_offset = v_off[i];
      @(negedge clk);
      idle();
      exp_retire++;
      n_cmp++; if (rf_wdata !== v_exp[i]) begin n_bad++; $display("FAIL load%0d_wdata got %h want %h", i, rf_wdata, v_exp[i]); end
      n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(10 + i)) begin
        n_bad++; $display("FAIL load%0d_port got wen=%b addr=%0d want wen=1 addr=%0d", i, rf_wen, rf_waddr, 10 + i);
      end
    end
    n_cmp++; if (retire_cnt !== exp_retire) begin n_bad++; $display("FAIL load_retire got %0d want %0d", retire_cnt, exp_retire); end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd12; ex_data = 64'hAA;
    ls_valid = 1; ls_rd = 5'd13; ls_data = 64'h55; ls_size = 2'd3;
    #1;
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL conflict_ex_ready got %b want 0", ex_ready); end
    n_cmp++; if (ls_ready !== 1'b1) begin n_bad++; $display("FAIL conflict_ls_ready got %b want 1", ls_ready); end
    @(negedge clk);
    ls_valid = 0;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL conflict_ex_ready2 got %b want 1", ex_ready); end
    n_cmp++; if (wb_valid !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 64'h55) begin
      n_bad++; $display("FAIL conflict_first got v=%b a=%0d d=%h want v=1 a=13 d=55", wb_valid, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    idle();
    n_cmp++; if (wb_valid !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 64'hAA) begin
      n_bad++; $display("FAIL conflict_second got v=%b a=%0d d=%h want v=1 a=12 d=aa", wb_valid, rf_waddr, rf_wdata);
    end
    exp_retire += 2;
    n_cmp++; if (retire_cnt !== exp_retire) begin n_bad++; $display("FAIL conflict_retire got %0d want %0d", retire_cnt, exp_retire); end
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL conflict_idle got %b want 0", wb_valid); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_wen = 1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd8;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_bad++; $display("FAIL sb_ready0 got %b want 1", iss_ready); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL sb_busy0 got %b want 0", rs1_busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (rs1_busy !== 1'b1) begin n_bad++; $display("FAIL sb_busy1 got %b want 1", rs1_busy); end
    n_cmp++; if (iss_ready !== 1'b0) begin n_bad++; $display("FAIL sb_waw got %b want 0", iss_ready); end
    iss_wen = 0;
    #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_bad++; $display("FAIL sb_nowen_ready got %b want 1", iss_ready); end
    iss_valid = 0;
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd7; ex_data = 64'h77;
    @(negedge clk);
    ex_valid = 0;
    // Issue x8 on the same edge x7 commits.
    iss_valid = 1; iss_wen = 1; iss_rd = 5'd8;
    exp_retire++;
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin
      n_bad++; $display("FAIL sb_commit got wen=%b a=%0d want wen=1 a=7", rf_wen, rf_waddr);
    end
    n_cmp++; if (rs1_busy !== 1'b1) begin n_bad++; $display("FAIL sb_busy_at_commit got %b want 1", rs1_busy); end
    @(negedge clk);
    iss_valid = 0; iss_rd = 5'd7;
    #1;
    n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL sb_busy_cleared got %b want 0", rs1_busy); end
    n_cmp++; if (rs2_busy !== 1'b1) begin n_bad++; $display("FAIL sb_set_other got %b want 1", rs2_busy); end
    n_cmp++; if (iss_ready !== 1'b1) begin n_bad++; $display("FAIL sb_ready_after got %b want 1", iss_ready); end
    ls_valid = 1; ls_rd = 5'd8; ls_data = 64'h8; ls_size = 2'd3;
    @(negedge clk);
    ls_valid = 0;
    exp_retire++;
    @(negedge clk);
    n_cmp++; if (rs2_busy !== 1'b0) begin n_bad++; $display("FAIL sb_x8_cleared got %b want 0", rs2_busy); end
    idle();
  endtask

  task automatic test_x0();
    ex_valid = 1; ex_wen = 1; ex_rd = 5'd0; ex_data = 64'hFFFF;
    @(negedge clk);
    ex_wen = 0; ex_rd = 5'd5; ex_data = 64'h1;
    exp_retire++;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL x0_rf_wen got %b want 0", rf_wen); end
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL x0_wb_valid got %b want 1", wb_valid); end
    n_cmp++; if (retire_cnt !== exp_retire) begin n_bad++; $display("FAIL x0_retire got %0d want %0d", retire_cnt, exp_retire); end
    @(negedge clk);
    idle();
    exp_retire++;
    n_cmp++; if (rf_wen !== 1'b0 || wb_valid !== 1'b1) begin
      n_bad++; $display("FAIL nowen got wen=%b v=%b want wen=0 v=1", rf_wen, wb_valid);
    end
    iss_valid = 1; iss_wen = 1; iss_rd = 5'd0; rs1 = 5'd0;
    @(negedge clk);
    #1;
    n_cmp++; if (rs1_busy !== 1'b0) begin n_bad++; $display("FAIL x0_busy got %b want 0", rs1_busy); end
    n_cmp++; if (iss_ready !== 1'b1) begin n_bad++; $display("FAIL x0_iss_ready got %b want 1", iss_ready); end
    n_cmp++; if (retire_cnt !== exp_retire) begin n_bad++; $display("FAIL final_retire got %0d want %0d", retire_cnt, exp_retire); end
    idle();
  endtask

  initial begin
    test_reset();
    test_ex_write();
    test_load_extend();
    test_back_to_back();
    test_scoreboard();
    test_x0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
